// File: rtl/rf_write_arbiter_pkg.sv
// rtl/rf_write_arbiter_pkg.sv - shared constants and types for the writeback arbiter
//
// Purpose: default widths, round-robin pointer encoding and the x0 index
//          shared by rf_write_arbiter and its wb_slot instances.
package rf_write_arbiter_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int ADDR_W_DEF = 5;
  localparam int X0_IDX     = 0;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_e;

endpackage

// File: rtl/rf_write_arbiter_wb_slot.sv
// rtl/rf_write_arbiter_wb_slot.sv - one-entry writeback holding slot
//
// Purpose: holds one pending register-file write (valid, rd, data) and
//          reports whether it targets a queried register.
// Ports:
//   i_clk, i_rst       clock, synchronous active-high reset
//   i_load             capture i_rd_in/i_data_in (wins over i_clear)
//   i_clear            slot was written to the register file this cycle
//   i_rd_in, i_data_in incoming destination register and data
//   o_full             slot holds a pending write
//   o_rd, o_data       pending write contents
//   i_q, o_match       hazard query address and its match flag
module wb_slot
  import rf_write_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic [ADDR_W-1:0] i_rd_in,
  input  logic [DATA_W-1:0] i_data_in,
  output logic              o_full,
  output logic [ADDR_W-1:0] o_rd,
  output logic [DATA_W-1:0] o_data,
  input  logic [ADDR_W-1:0] i_q,
  output logic              o_match
);

  logic              r_full;
  logic [ADDR_W-1:0] r_rd;
  logic [DATA_W-1:0] r_data;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_full <= 1'b0;
      r_rd   <= '0;
      r_data <= '0;
    end else if (i_load) begin
      // A write to x0 is accepted but never becomes pending.
      r_full <= (i_rd_in != ADDR_W'(X0_IDX));
      r_rd   <= i_rd_in;
      r_data <= i_data_in;
    end else if (i_clear) begin
      r_full <= 1'b0;
    end
  end

  assign o_full  = r_full;
  assign o_rd    = r_rd;
  assign o_data  = r_data;
  assign o_match = r_full && (r_rd == i_q) && (i_q != ADDR_W'(X0_IDX));

endmodule

// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - round-robin arbiter for the single register-file write port
//
// Purpose: two requesters (A = ALU, B = load unit) each feed a one-entry slot;
//          slots drain one write per cycle, round-robin on contention, and
//          pending writes are reported as hazards against two query addresses.
// Ports:
//   i_clk, i_rst                       clock, synchronous active-high reset
//   i_a_valid/i_a_rd/i_a_data, o_a_ready   requester A handshake
//   i_b_valid/i_b_rd/i_b_data, o_b_ready   requester B handshake
//   o_rf_we/o_rf_rw/o_rf_din           register-file write port
//   i_qa/i_qb, o_hz_a/o_hz_b           hazard queries and flags
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_a_valid,
  input  logic [ADDR_W-1:0] i_a_rd,
  input  logic [DATA_W-1:0] i_a_data,
  output logic              o_a_ready,
  input  logic              i_b_valid,
  input  logic [ADDR_W-1:0] i_b_rd,
  input  logic [DATA_W-1:0] i_b_data,
  output logic              o_b_ready,
  output logic              o_rf_we,
  output logic [ADDR_W-1:0] o_rf_rw,
  output logic [DATA_W-1:0] o_rf_din,
  input  logic [ADDR_W-1:0] i_qa,
  input  logic [ADDR_W-1:0] i_qb,
  output logic              o_hz_a,
  output logic              o_hz_b
);

  req_e              r_rr_ptr;
  logic              r_post_rst;
  logic              w_a_full, w_b_full;
  logic [ADDR_W-1:0] w_a_rd, w_b_rd;
  logic [DATA_W-1:0] w_a_data, w_b_data;
  logic              w_a_qa, w_a_qb, w_b_qa, w_b_qb;
  logic              w_gnt_a, w_gnt_b;
  logic              w_a_ready, w_b_ready;
  logic              w_a_load, w_b_load;

  // Held for the first cycle after reset so requesters see ready low there.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_post_rst <= 1'b1;
    else       r_post_rst <= 1'b0;
  end

  // Pointer moves only when both slots compete.
  always_ff @(posedge i_clk) begin
    if (i_rst)
      r_rr_ptr <= REQ_A;
    else if (w_a_full && w_b_full)
      r_rr_ptr <= (r_rr_ptr == REQ_A) ? REQ_B : REQ_A;
  end

  // Reset gating suppresses writes from slots still full in a mid-flight reset cycle.
  assign w_gnt_a = !i_rst && w_a_full && (!w_b_full || (r_rr_ptr == REQ_A));
  assign w_gnt_b = !i_rst && w_b_full && (!w_a_full || (r_rr_ptr == REQ_B));

  // A slot drained this cycle can be refilled at the same edge.
  assign w_a_ready = !i_rst && !r_post_rst && (!w_a_full || w_gnt_a);
  assign w_b_ready = !i_rst && !r_post_rst && (!w_b_full || w_gnt_b);
  assign w_a_load  = i_a_valid && w_a_ready;
  assign w_b_load  = i_b_valid && w_b_ready;

  wb_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot_a_qa (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_load    (w_a_load),
    .i_clear   (w_gnt_a),
    .i_rd_in   (i_a_rd),
    .i_data_in (i_a_data),
    .o_full    (w_a_full),
    .o_rd      (w_a_rd),
    .o_data    (w_a_data),
    .i_q       (i_qa),
    .o_match   (w_a_qa)
  );

  wb_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot_b_qa (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_load    (w_b_load),
    .i_clear   (w_gnt_b),
    .i_rd_in   (i_b_rd),
    .i_data_in (i_b_data),
    .o_full    (w_b_full),
    .o_rd      (w_b_rd),
    .o_data    (w_b_data),
    .i_q       (i_qa),
    .o_match   (w_b_qa)
  );

  // Second query port compares against the same registered slot contents.
  assign w_a_qb = w_a_full && (w_a_rd == i_qb) && (i_qb != ADDR_W'(X0_IDX));
  assign w_b_qb = w_b_full && (w_b_rd == i_qb) && (i_qb != ADDR_W'(X0_IDX));

  assign o_a_ready = w_a_ready;
  assign o_b_ready = w_b_ready;
  assign o_rf_we   = w_gnt_a || w_gnt_b;
  assign o_rf_rw   = w_gnt_a ? w_a_rd   : (w_gnt_b ? w_b_rd   : '0);
  assign o_rf_din  = w_gnt_a ? w_a_data : (w_gnt_b ? w_b_data : '0);

  // A slot granted this cycle still reports a hazard; its data lands after this edge.
  assign o_hz_a = !i_rst && (w_a_qa || w_b_qa);
  assign o_hz_b = !i_rst && (w_a_qb || w_b_qb);

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb/tb_rf_write_arbiter.sv - scoreboard bench for rf_write_arbiter
module tb_rf_write_arbiter;

  typedef struct {
    logic [4:0]  rw;
    logic [63:0] din;
  } wr_t;

  bit          clk;
  logic        rst;
  logic        a_valid, b_valid;
  logic [4:0]  a_rd, b_rd, qa, qb;
  logic [63:0] a_data, b_data;
  logic        a_ready, b_ready, rf_we, hz_a, hz_b;
  logic [4:0]  rf_rw;
  logic [63:0] rf_din;

  int          n_tests = 0;
  int          n_fail  = 0;
  wr_t         exp_q[$];
  logic [63:0] shadow[32];

  rf_write_arbiter #(.DATA_W(64), .ADDR_W(5)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_a_valid (a_valid),
    .i_a_rd    (a_rd),
    .i_a_data  (a_data),
    .o_a_ready (a_ready),
    .i_b_valid (b_valid),
    .i_b_rd    (b_rd),
    .i_b_data  (b_data),
    .o_b_ready (b_ready),
    .o_rf_we   (rf_we),
    .o_rf_rw   (rf_rw),
    .o_rf_din  (rf_din),
    .i_qa      (qa),
    .i_qb      (qb),
    .o_hz_a    (hz_a),
    .o_hz_b    (hz_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] rw, input logic [63:0] din);
    wr_t e;
    e.rw  = rw;
    e.din = din;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    a_valid = 0;
    b_valid = 0;
    rst = 1;
    tick();
    rst = 0;
    tick();
    tick();
  endtask

  // Monitor: every write on the RF port must match the next expected write.
  always @(negedge clk) begin
    wr_t e;
    if (rf_we) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: got rw=%0d din=%0h, required no write", rf_rw, rf_din);
      end else begin
        e = exp_q.pop_front();
        chk("wr_rw", 64'(rf_rw), 64'(e.rw));
        chk("wr_din", rf_din, e.din);
        shadow[rf_rw] = rf_din;
      end
    end else begin
      chk("idle_rw", 64'(rf_rw), 64'd0);
      chk("idle_din", rf_din, 64'd0);
    end
  end

  initial begin
    int ai, bi;
    rst = 1; a_valid = 1; a_rd = 0; a_data = 0;
    b_valid = 0; b_rd = 0; b_data = 0; qa = 0; qb = 0;
    for (int i = 0; i < 32; i++) shadow[i] = '0;

    // Reset held two cycles with A offering
    repeat (2) begin
      @(negedge clk);
      chk("rst_a_ready", 64'(a_ready), 64'd0);
      chk("rst_rf_we", 64'(rf_we), 64'd0);
      chk("rst_hz_a", 64'(hz_a), 64'd0);
      tick();
    end
    rst = 0;
    @(negedge clk);
    chk("post_rst1_a_ready", 64'(a_ready), 64'd0);
    chk("post_rst1_b_ready", 64'(b_ready), 64'd0);
    tick();
    @(negedge clk);
    chk("post_rst2_a_ready", 64'(a_ready), 64'd1);
    chk("post_rst2_b_ready", 64'(b_ready), 64'd1);
    tick();
    a_valid = 0;

    // Single write from A
    do_reset();
    a_valid = 1; a_rd = 5; a_data = 64'hDEAD_BEEF; qa = 5;
    push(5, 64'hDEAD_BEEF);
    @(negedge clk);
    chk("single_a_ready", 64'(a_ready), 64'd1);
    chk("single_hz_before", 64'(hz_a), 64'd0);
    tick();
    a_valid = 0;
    @(negedge clk);
    chk("single_rf_we", 64'(rf_we), 64'd1);
    chk("single_hz_n1", 64'(hz_a), 64'd1);
    tick();
    @(negedge clk);
    chk("single_hz_n2", 64'(hz_a), 64'd0);
    tick();

    // Contention: alternate A,B grants
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push(5'(1 + i), 64'(32'hA0 + i));
      push(5'(11 + i), 64'(32'hB0 + i));
    end
    ai = 0; bi = 0;
    for (int c = 0; c < 10; c++) begin
      a_valid = (ai < 4); a_rd = 5'(1 + ai);  a_data = 64'(32'hA0 + ai);
      b_valid = (bi < 4); b_rd = 5'(11 + bi); b_data = 64'(32'hB0 + bi);
      @(negedge clk);
      if (c >= 1 && c <= 8) chk("cont_rf_we", 64'(rf_we), 64'd1);
      if (c >= 1 && c <= 4) begin
        chk("cont_a_ready", 64'(a_ready), 64'(c % 2 == 1));
        chk("cont_b_ready", 64'(b_ready), 64'(c % 2 == 0));
      end
      if (a_valid && a_ready) ai++;
      if (b_valid && b_ready) bi++;
      tick();
    end
    a_valid = 0; b_valid = 0;

    // Write to x0 is dropped
    do_reset();
    b_valid = 1; b_rd = 0; b_data = 64'hFFFF; qb = 0;
    repeat (3) begin
      @(negedge clk);
      chk("x0_b_ready", 64'(b_ready), 64'd1);
      chk("x0_rf_we", 64'(rf_we), 64'd0);
      chk("x0_hz_b", 64'(hz_b), 64'd0);
      tick();
    end
    b_valid = 0;
    tick();

    // Same rd in both slots, rr_ptr=A
    do_reset();
    qa = 7;
    a_valid = 1; a_rd = 7; a_data = 64'd1;
    b_valid = 1; b_rd = 7; b_data = 64'd2;
    push(7, 64'd1);
    push(7, 64'd2);
    @(negedge clk);
    chk("same_hz_s0", 64'(hz_a), 64'd0);
    tick();
    a_valid = 0; b_valid = 0;
    @(negedge clk);
    chk("same_hz_s1", 64'(hz_a), 64'd1);
    tick();
    @(negedge clk);
    chk("same_hz_s2", 64'(hz_a), 64'd1);
    tick();
    @(negedge clk);
    chk("same_hz_s3", 64'(hz_a), 64'd0);
    chk("same_final_x7", shadow[7], 64'd2);
    tick();

    // Reset mid-flight with both slots full
    do_reset();
    qa = 20;
    a_valid = 1; a_rd = 20; a_data = 64'h20;
    b_valid = 1; b_rd = 21; b_data = 64'h21;
    tick();
    a_valid = 0; b_valid = 0; rst = 1;
    @(negedge clk);
    chk("mid_rst_rf_we", 64'(rf_we), 64'd0);
    chk("mid_rst_hz_a", 64'(hz_a), 64'd0);
    tick();
    rst = 0;
    @(negedge clk);
    chk("mid_post1_rf_we", 64'(rf_we), 64'd0);
    chk("mid_post1_a_ready", 64'(a_ready), 64'd0);
    tick();
    @(negedge clk);
    chk("mid_post2_rf_we", 64'(rf_we), 64'd0);
    chk("mid_post2_a_ready", 64'(a_ready), 64'd1);
    chk("mid_post2_hz_a", 64'(hz_a), 64'd0);
    a_valid = 1; a_rd = 22; a_data = 64'h22;
    b_valid = 1; b_rd = 23; b_data = 64'h23;
    push(22, 64'h22);
    push(23, 64'h23);
    tick();
    a_valid = 0; b_valid = 0;
    @(negedge clk);
    chk("mid_rr_first_grant_a", 64'(rf_rw), 64'd22);
    tick();
    tick();
    tick();

    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
